// File: rtl/fp_reduce_pkg.sv
// Shared types for the streaming FP32 reduction sequencer: FSM states,
// operand-source select encoding and the FP32 zero constant.
package fp_reduce_pkg;

  typedef enum logic [1:0] {
    ST_FLUSH = 2'd0,
    ST_IDLE  = 2'd1,
    ST_ACCUM = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Candidate operand sources, listed in issue priority order
  typedef enum logic [1:0] {
    SRC_R    = 2'd0,
    SRC_I    = 2'd1,
    SRC_H    = 2'd2,
    SRC_NONE = 2'd3
  } src_e;

  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

endpackage

// File: rtl/fp_reduce_pick.sv
// Combinational priority selector: takes adder result (R), accepted input (I)
// and hold register (H) and decides between issuing an add or parking a value.
module fp_reduce_pick
  import fp_reduce_pkg::*;
(
  input  logic        r_valid,
  input  logic [31:0] r_data,
  input  logic        i_valid,
  input  logic [31:0] i_data,
  input  logic        h_valid,
  input  logic [31:0] h_data,
  output logic        issue,
  output logic [31:0] opA,
  output logic [31:0] opB,
  output logic        hold_wr,
  output logic [31:0] hold_data,
  output logic        hold_consume
);

  src_e sel_a;
  src_e sel_b;

  function automatic logic [31:0] src_mux(input src_e sel, input logic [31:0] r,
                                          input logic [31:0] i, input logic [31:0] h);
    case (sel)
      SRC_R:   return r;
      SRC_I:   return i;
      SRC_H:   return h;
      default: return FP32_ZERO;
    endcase
  endfunction

  always_comb begin
    sel_a = SRC_NONE;
    sel_b = SRC_NONE;
    if (r_valid) begin
      sel_a = SRC_R;
      if (i_valid)      sel_b = SRC_I;
      else if (h_valid) sel_b = SRC_H;
    end else if (i_valid) begin
      sel_a = SRC_I;
      if (h_valid) sel_b = SRC_H;
    end else if (h_valid) begin
      sel_a = SRC_H;
    end
  end

  // A lone R or I is parked; a lone H stays where it is
  always_comb begin
    issue        = (sel_b != SRC_NONE);
    hold_consume = issue && (sel_b == SRC_H);
    hold_wr      = !issue && ((sel_a == SRC_R) || (sel_a == SRC_I));
    opA          = src_mux(sel_a, r_data, i_data, h_data);
    opB          = src_mux(sel_b, r_data, i_data, h_data);
    hold_data    = opA;
  end

endmodule

// File: rtl/fp_reduce_ctrl.sv
// Streaming FP32 reduction sequencer time-sharing one external pipelined adder.
// Optional FP_REDUCE_STATS_EN adds the Add_Count per-run issue counter output.
module fp_reduce_ctrl
  import fp_reduce_pkg::*;
#(
  parameter int ADD_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Start,
  input  logic [CNT_W-1:0] Length,
  input  logic [31:0]      Data_In,
  input  logic             Valid_In,
  output logic             Ready_In,
  output logic [31:0]      Data_Out,
  output logic             Valid_Out,
  output logic             Busy,
  output logic [31:0]      Add_A,
  output logic [31:0]      Add_B,
  output logic             Add_Valid,
  input  logic [31:0]      Add_Result,
  input  logic             Add_Result_Valid
`ifdef FP_REDUCE_STATS_EN
  ,
  output logic [CNT_W-1:0] Add_Count
`endif
);

  localparam int INF_W = $clog2(ADD_LAT + 3);
  localparam int FL_W  = $clog2(ADD_LAT + 2);

  state_e             state_reg, state_next;
  logic [FL_W-1:0]    flush_cnt_reg;
  logic [CNT_W-1:0]   len_reg;
  logic [CNT_W-1:0]   acc_cnt_reg;
  logic [INF_W-1:0]   inflight_reg;
  logic [31:0]        hold_data_reg;
  logic               hold_valid_reg;
  logic [31:0]        data_out_reg;
  logic [31:0]        add_a_reg, add_b_reg;
  logic               add_valid_reg;

  logic               in_accum, accept, start_ok, finish;
  logic               r_valid, h_valid;
  logic               issue, hold_wr, hold_consume;
  logic [31:0]        op_a, op_b, pick_hold_data;

  assign in_accum = (state_reg == ST_ACCUM);
  assign Ready_In = in_accum && (acc_cnt_reg < len_reg);
  assign accept   = Valid_In && Ready_In;
  assign start_ok = (state_reg == ST_IDLE) && Start;
  // Adder results only count while a run is accumulating
  assign r_valid  = in_accum && Add_Result_Valid;
  assign h_valid  = in_accum && hold_valid_reg;
  assign finish   = in_accum && (acc_cnt_reg == len_reg) && (inflight_reg == '0)
                    && hold_valid_reg && !Add_Result_Valid;

  fp_reduce_pick u_pick (
    .r_valid      (r_valid),
    .r_data       (Add_Result),
    .i_valid      (accept),
    .i_data       (Data_In),
    .h_valid      (h_valid),
    .h_data       (hold_data_reg),
    .issue        (issue),
    .opA          (op_a),
    .opB          (op_b),
    .hold_wr      (hold_wr),
    .hold_data    (pick_hold_data),
    .hold_consume (hold_consume)
  );

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_FLUSH;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_FLUSH: if (flush_cnt_reg == FL_W'(ADD_LAT)) state_next = ST_IDLE;
      ST_IDLE:  if (Start) state_next = (Length == '0) ? ST_DONE : ST_ACCUM;
      ST_ACCUM: if (finish) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_FLUSH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt_reg  <= '0;
      len_reg        <= '0;
      acc_cnt_reg    <= '0;
      inflight_reg   <= '0;
      hold_data_reg  <= FP32_ZERO;
      hold_valid_reg <= 1'b0;
      data_out_reg   <= FP32_ZERO;
      add_a_reg      <= FP32_ZERO;
      add_b_reg      <= FP32_ZERO;
      add_valid_reg  <= 1'b0;
    end else begin
      flush_cnt_reg <= (state_reg == ST_FLUSH) ? flush_cnt_reg + 1'b1 : '0;

      add_valid_reg <= issue;
      if (issue) begin
        add_a_reg <= op_a;
        add_b_reg <= op_b;
      end

      if (start_ok) begin
        len_reg     <= Length;
        acc_cnt_reg <= '0;
      end else if (accept) begin
        acc_cnt_reg <= acc_cnt_reg + 1'b1;
      end

      inflight_reg <= inflight_reg + INF_W'(issue) - INF_W'(r_valid);

      if (state_reg == ST_DONE) begin
        hold_valid_reg <= 1'b0;
      end else if (hold_wr) begin
        hold_data_reg  <= pick_hold_data;
        hold_valid_reg <= 1'b1;
      end else if (hold_consume) begin
        hold_valid_reg <= 1'b0;
      end

      if (start_ok && (Length == '0)) data_out_reg <= FP32_ZERO;
      else if (finish)                data_out_reg <= hold_data_reg;
    end
  end

`ifdef FP_REDUCE_STATS_EN
  logic [CNT_W-1:0] add_count_reg;

  always_ff @(posedge clk) begin
    if (rst || start_ok) add_count_reg <= '0;
    else if (issue)      add_count_reg <= add_count_reg + 1'b1;
  end

  assign Add_Count = add_count_reg;
`endif

  assign Data_Out  = data_out_reg;
  assign Valid_Out = (state_reg == ST_DONE);
  assign Busy      = (state_reg != ST_IDLE);
  assign Add_A     = add_a_reg;
  assign Add_B     = add_b_reg;
  assign Add_Valid = add_valid_reg;

endmodule

// File: tb/tb_fp_reduce_ctrl.sv
// Self-checking bench for fp_reduce_ctrl with an integer-valued FP32 adder model
// and a sum-of-operands reference for every run.
module tb_fp_reduce_ctrl;

  localparam int ADD_LAT = 4;
  localparam int CNT_W   = 16;

  logic             clk;
  logic             rst;
  logic             Start;
  logic [CNT_W-1:0] Length;
  logic [31:0]      Data_In;
  logic             Valid_In;
  logic             Ready_In;
  logic [31:0]      Data_Out;
  logic             Valid_Out;
  logic             Busy;
  logic [31:0]      Add_A, Add_B;
  logic             Add_Valid;
  logic [31:0]      Add_Result;
  logic             Add_Result_Valid;
`ifdef FP_REDUCE_STATS_EN
  logic [CNT_W-1:0] add_count;
`endif

  fp_reduce_ctrl #(.ADD_LAT(ADD_LAT), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .Start            (Start),
    .Length           (Length),
    .Data_In          (Data_In),
    .Valid_In         (Valid_In),
    .Ready_In         (Ready_In),
    .Data_Out         (Data_Out),
    .Valid_Out        (Valid_Out),
    .Busy             (Busy),
    .Add_A            (Add_A),
    .Add_B            (Add_B),
    .Add_Valid        (Add_Valid),
    .Add_Result       (Add_Result),
`ifdef FP_REDUCE_STATS_EN
    .Add_Count        (add_count),
`endif
    .Add_Result_Valid (Add_Result_Valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Positive integer-valued FP32 helpers (values below 2^24)
  function automatic logic [31:0] to_fp(input int v);
    int p;
    logic [31:0] m;
    if (v <= 0) return 32'h0;
    p = 0;
    for (int b = 0; b < 31; b++) if (v[b]) p = b;
    m = 32'(v) << (23 - p);
    return {1'b0, 8'(127 + p), m[22:0]};
  endfunction

  function automatic int from_fp(input logic [31:0] f);
    int e;
    int m;
    e = int'(f[30:23]);
    if (e < 127 || e > 150) return 0;
    m = int'({1'b1, f[22:0]});
    return m >>> (150 - e);
  endfunction

  // External adder: fixed ADD_LAT-cycle pipeline, never reset
  bit [31:0] pipe_d [ADD_LAT];
  bit        pipe_v [ADD_LAT];
  always @(posedge clk) begin
    pipe_v[0] <= Add_Valid;
    pipe_d[0] <= to_fp(from_fp(Add_A) + from_fp(Add_B));
    for (int k = 1; k < ADD_LAT; k++) begin
      pipe_v[k] <= pipe_v[k-1];
      pipe_d[k] <= pipe_d[k-1];
    end
  end
  assign Add_Result       = pipe_d[ADD_LAT-1];
  assign Add_Result_Valid = pipe_v[ADD_LAT-1];

  int          total = 0;
  int          bad = 0;
  int          vo_count = 0;
  int          vo_cyc = 0;
  int          add_cnt = 0;
  int          outstanding = 0;
  bit          exp_armed = 0;
  logic [31:0] exp_data = 32'h0;
  int          ops [64];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Per-cycle comparison against the run model, sampled on the falling edge
  task automatic cycle_compare();
    if (Add_Valid) begin
      add_cnt++;
      outstanding++;
    end
    if (Add_Result_Valid && exp_armed) outstanding--;
    if (exp_armed) begin
      total++;
      if (outstanding > ADD_LAT + 1) begin
        bad++;
        $display("FAIL inflight_bound: got %0d expected <= %0d", outstanding, ADD_LAT + 1);
      end
    end
    if (Valid_Out) begin
      vo_count++;
      vo_cyc = cyc;
      total++;
      if (!exp_armed) begin
        bad++;
        $display("FAIL unexpected_valid_out: got data %h expected no pulse", Data_Out);
      end else if (Data_Out !== exp_data) begin
        bad++;
        $display("FAIL data_out: got %h expected %h", Data_Out, exp_data);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cycle_compare();
    @(posedge clk);
    #1;
  endtask

  task automatic run_case(input string name, input int len, input bit gaps,
                          input logic [31:0] exp_lit);
    int idx, guard, sum, pulses0, adds0, acc_cyc;
    bit acc;
    sum = 0;
    for (int i = 0; i < len; i++) sum += ops[i];
    check({"model_", name}, to_fp(sum), exp_lit);
    guard = 0;
    while (Busy && guard < 100) begin
      tick();
      guard++;
    end
    check({"idle_before_", name}, 32'(Busy), 32'd0);
    exp_data  = exp_lit;
    exp_armed = 1;
    pulses0   = vo_count;
    adds0     = add_cnt;
    acc_cyc   = 0;
    Start  = 1'b1;
    Length = CNT_W'(len);
    tick();
    Start = 1'b0;
    idx = 0;
    guard = 0;
    while (idx < len && guard < 1000) begin
      Data_In  = to_fp(ops[idx]);
      Valid_In = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (!gaps) check({"ready_in_", name}, 32'(Ready_In), 32'd1);
      acc = Valid_In && Ready_In;
      if (acc) acc_cyc = cyc;
      tick();
      if (acc) idx++;
      guard++;
    end
    Valid_In = 1'b0;
    check({"all_accepted_", name}, 32'(idx), 32'(len));
    guard = 0;
    while (vo_count == pulses0 && guard < 300) begin
      tick();
      guard++;
    end
    check({"pulse_count_", name}, 32'(vo_count - pulses0), 32'd1);
    check({"busy_after_", name}, 32'(Busy), 32'd0);
    check({"adds_", name}, 32'(add_cnt - adds0), 32'(len > 0 ? len - 1 : 0));
`ifdef FP_REDUCE_STATS_EN
    check({"add_count_", name}, 32'(add_count), 32'(len > 0 ? len - 1 : 0));
`endif
    if (len == 1) check({"latency_", name}, 32'(vo_cyc - acc_cyc), 32'd2);
    tick();
    tick();
    check({"data_hold_", name}, Data_Out, exp_lit);
    exp_armed = 0;
    $display("run %s len=%0d data_out=%h expected=%h adds=%0d", name, len, Data_Out,
             exp_lit, add_cnt - adds0);
  endtask

  initial begin
    int guard, pulses0;
    rst = 1'b1;
    Start = 1'b0;
    Length = '0;
    Data_In = 32'h0;
    Valid_In = 1'b0;
    @(posedge clk);
    #1;
    tick();
    check("rst_data_out", Data_Out, 32'h0);
    check("rst_valid_out", 32'(Valid_Out), 32'd0);
    check("rst_ready_in", 32'(Ready_In), 32'd0);
    check("rst_busy", 32'(Busy), 32'd1);
    check("rst_add_valid", 32'(Add_Valid), 32'd0);
    check("rst_add_a", Add_A, 32'h0);
    check("rst_add_b", Add_B, 32'h0);
    tick();
    rst = 1'b0;
    outstanding = 0;
    // Start held through the drain window must be ignored
    Start = 1'b1;
    Length = CNT_W'(1);
    for (int k = 0; k <= ADD_LAT; k++) begin
      check("flush_busy", 32'(Busy), 32'd1);
      check("flush_ready", 32'(Ready_In), 32'd0);
      tick();
    end
    Start = 1'b0;
    check("flush_exit_idle", 32'(Busy), 32'd0);
    tick();
    check("flush_start_ignored", 32'(Busy), 32'd0);
    $display("run flush busy=%0d", Busy);

    run_case("len0", 0, 1'b0, 32'h0000_0000);

    ops[0] = 3;
    run_case("len1", 1, 1'b0, 32'h4040_0000);

    for (int i = 0; i < 8; i++) ops[i] = 1;
    run_case("len8", 8, 1'b0, 32'h4100_0000);

    for (int i = 0; i < 64; i++) ops[i] = i + 1;
    run_case("len64", 64, 1'b1, 32'h4502_0000);

    // Abort after 5 of 16 operands
    for (int i = 0; i < 16; i++) ops[i] = i + 1;
    pulses0 = vo_count;
    Start = 1'b1;
    Length = CNT_W'(16);
    tick();
    Start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      Data_In = to_fp(ops[i]);
      Valid_In = 1'b1;
      tick();
    end
    Valid_In = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    outstanding = 0;
    guard = 0;
    while (Busy && guard < 50) begin
      tick();
      guard++;
    end
    check("abort_no_pulse", 32'(vo_count - pulses0), 32'd0);
    check("abort_reaches_idle", 32'(Busy), 32'd0);
    $display("run abort pulses=%0d", vo_count - pulses0);

    ops[0] = 2;
    ops[1] = 4;
    run_case("len2_after_abort", 2, 1'b0, 32'h40C0_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
